// File: rtl/matmul_stream_driver.sv
// Host-side stream driver for the 2x2 unsigned matrix-multiplier core: loads eight
// operand elements, pulses the core once, captures its result and streams it back as four beats.
module matmul_stream_driver #(
    parameter int MM_LATENCY = 1,
    parameter int ELEM_MAX   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] in_data,
    output logic [7:0] mm_a,
    output logic [7:0] mm_b,
    output logic       mm_ena,
    input  logic [7:0] mm_c_lo,
    input  logic [7:0] mm_c_hi,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_data,
    output logic       out_last,
    output logic       out_err,
    output logic       busy
);
    typedef enum logic [1:0] {LOAD, ISSUE, WAIT, DRAIN} state_t;

    localparam logic [2:0] EMAX = 3'(ELEM_MAX);
    localparam logic [3:0] LAT  = 4'(MM_LATENCY);

    state_t      state, state_nxt;
    logic [2:0]  cnt;
    logic        err;
    logic [3:0]  wait_cnt;
    logic [1:0]  beat;
    logic [15:0] res;
    logic [3:0]  nib;
    logic        accept;
    logic        beat_done;

    // Handshakes decoded from state directly so the FSM block never reads its own outputs.
    assign accept    = in_valid && (state == LOAD);
    assign beat_done = out_ready && (state == DRAIN);
    assign nib       = res[{beat, 2'b00} +: 4];
    assign busy      = (state != LOAD) || (cnt != 3'd0);

    always_ff @(posedge clk) begin
        if (reset) state <= LOAD;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        mm_ena    = 1'b0;
        out_valid = 1'b0;
        out_data  = 4'd0;
        out_last  = 1'b0;
        out_err   = 1'b0;
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && cnt == 3'd7) state_nxt = ISSUE;
            end
            ISSUE: begin
                mm_ena    = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (wait_cnt == 4'd1) state_nxt = DRAIN;
            end
            DRAIN: begin
                out_valid = 1'b1;
                out_last  = (beat == 2'd3);
                out_err   = err;
                out_data  = err ? 4'd0 : nib;
                if (out_ready && beat == 2'd3) state_nxt = LOAD;
            end
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= 3'd0;
            err      <= 1'b0;
            mm_a     <= 8'd0;
            mm_b     <= 8'd0;
            wait_cnt <= 4'd0;
            beat     <= 2'd0;
            res      <= 16'd0;
        end else begin
            if (accept) begin
                if (!cnt[2]) mm_a[{cnt[1:0], 1'b0} +: 2] <= in_data;
                else         mm_b[{cnt[1:0], 1'b0} +: 2] <= in_data;
                if ({1'b0, in_data} > EMAX) err <= 1'b1;
                // Wraps to zero on the eighth element, ready for the next matrix.
                cnt <= cnt + 3'd1;
            end
            if (state == ISSUE) wait_cnt <= LAT;
            if (state == WAIT) begin
                wait_cnt <= wait_cnt - 4'd1;
                if (wait_cnt == 4'd1) res <= {mm_c_hi, mm_c_lo};
            end
            if (beat_done) begin
                beat <= beat + 2'd1;
                if (beat == 2'd3) err <= 1'b0;
            end
        end
    end
endmodule

// File: doc/matmul_stream_driver.md
Name: matmul_stream_driver

Overview:
- Host-side initiator for the 2x2 unsigned matrix-multiplier core.
- Accepts eight 2-bit operand elements over a valid/ready stream and packs them into the core's A/B operand words.
- Issues one enable pulse to the core, waits the core latency, then captures the packed 4-bit results.
- Returns the results as a four-beat valid/ready result stream with a per-matrix error flag.

Parameters:
- MM_LATENCY, 1, cycles after the issue cycle before the core result is stable (1..15).
- ELEM_MAX, 2, largest legal operand element value; larger values flag an error.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand element valid.
- in_ready  output  1  driver can accept an operand element.
- in_data  input  2  element; order a11,a12,a21,a22,b11,b12,b21,b22.
- mm_a  output  8  to core A word: [1:0]=a11, [3:2]=a12, [5:4]=a21, [7:6]=a22.
- mm_b  output  8  to core B word, same packing with b elements.
- mm_ena  output  1  core enable, one-cycle pulse per matrix.
- mm_c_lo  input  8  core result: [3:0]=c11, [7:4]=c12.
- mm_c_hi  input  8  core result: [3:0]=c21, [7:4]=c22.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts the beat.
- out_data  output  4  result element; order c11,c12,c21,c22.
- out_last  output  1  high on the c22 beat.
- out_err  output  1  matrix contained an out-of-range element; constant over all 4 beats.
- busy  output  1  high in any state other than LOAD, or in LOAD with elem count >0.

Behaviour:
- States: LOAD, ISSUE, WAIT, DRAIN.
- Reset (synchronous, highest priority, any state incl. mid-load/mid-drain):
  - state=LOAD, elem count=0, err=0.
  - mm_a=mm_b=0, mm_ena=0, out_valid=0, out_data=0, out_last=0, out_err=0.
  - Partial matrices are discarded; reset asserted on an accept edge discards that element.
- LOAD:
  - in_ready=1; accept on in_valid&&in_ready.
  - Each accepted element is written into its mm_a/mm_b slot per count 0..7.
  - If in_data>ELEM_MAX, err is set (sticky until the next matrix starts).
  - in_valid gaps are allowed; no timeout.
  - On the 8th accept, go to ISSUE; in_ready=0 from the next cycle.
- ISSUE (1 cycle): mm_ena=1. mm_a/mm_b are held stable from the last accept through the end of WAIT.
- WAIT:
  - Counter starts at MM_LATENCY.
  - Capture mm_c_lo/mm_c_hi on the edge ending the MM_LATENCY-th cycle after ISSUE, then go to DRAIN.
  - With MM_LATENCY=1: ISSUE at T, capture at end of T+1, first out_valid at T+2.
- DRAIN:
  - out_valid=1; out_data = captured c11, c12, c21, c22 in that order.
  - Beat advances only on out_valid&&out_ready; out_data/out_last/out_err are held stable while stalled.
  - If err=1, every out_data is forced to 0 regardless of captured value; out_err=1 on all four beats.
  - After the c22 handshake: go to LOAD, count=0, err=0, out_valid=0.
  - The first element of the next matrix can be accepted in the following cycle.
- No overlap: operands are never accepted during ISSUE/WAIT/DRAIN; at most one matrix in flight.
- Arithmetic: result elements are 4-bit unsigned, max 2*2+2*2=8. The driver does not recompute; it only captures and forwards.
- mm_ena is never asserted outside ISSUE.

Test Plan:
- Basic: A=[[1,2],[0,1]], B=[[2,1],[1,0]], out_ready=1 -> mm_a=0x49, mm_b=0x16, one mm_ena pulse, beats 4,1,1,0; out_last on beat 4; out_err=0.
- Max values: all eight elements=2 -> beats 8,8,8,8, out_err=0. Identity A=[[1,0],[0,1]] with B=[[2,1],[1,2]] -> 2,1,1,2.
- Error: a12=3, rest 1 -> mm_ena still pulses; beats 0,0,0,0 with out_err=1 on each. The next valid matrix has out_err=0.
- Backpressure: out_ready low for 3 cycles on beat 2 -> out_data stays at c12 and out_valid held; no beat skipped or repeated; in_ready stays 0 until c22 accepted.
- Reset mid-operation: reset after 5 accepted elements, and again mid-DRAIN -> all outputs 0 next cycle. A subsequent full matrix produces correct results with no stale elements.
- Back-to-back with gaps: two matrices, in_valid toggling every other cycle, MM_LATENCY=3 -> exactly one mm_ena per matrix; capture occurs 3 cycles after ISSUE; both result streams correct.
